alu_operand_stage: RTL

// - Decode->execute pipeline stage directly upstream of the ALU: registers decoded instruction fields,

---
 rtl/alu_operand_stage_if.sv | 54 +++++
 rtl/alu_operand_stage.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage_if.sv
// Decode->execute bus for alu_operand_stage: upstream instruction fields, writeback snoop
// and the ALU-side operand outputs. slave = the stage itself, master = its environment.
interface alu_operand_stage_if #(
    parameter int XLEN = 32
);
    logic            i_flush;
    logic            i_valid;
    logic            o_ready;
    logic [XLEN-1:0] i_pc;
    logic [XLEN-1:0] i_rs1_data;
    logic [XLEN-1:0] i_rs2_data;
    logic [XLEN-1:0] i_imm;
    logic [4:0]      i_rs1_addr;
    logic [4:0]      i_rs2_addr;
    logic [4:0]      i_rd_addr;
    logic            i_use_pc;
    logic            i_use_imm;
    logic [2:0]      i_alu_op;
    logic            i_sub;
    logic            i_arith_shift;
    logic [2:0]      i_branch_op;
    logic            i_wb_valid;
    logic [4:0]      i_wb_rd;
    logic [XLEN-1:0] i_wb_data;
    logic            o_valid;
    logic            i_ready;
    logic [XLEN-1:0] o_a;
    logic [XLEN-1:0] o_b;
    logic [XLEN-1:0] o_rs2_val;
    logic [2:0]      o_op;
    logic [2:0]      o_branch_op;
    logic            o_sub;
    logic            o_arith_shift;
    logic [XLEN-1:0] o_pc;
    logic [4:0]      o_rd;

    modport slave (
        input  i_flush, i_valid, i_pc, i_rs1_data, i_rs2_data, i_imm,
               i_rs1_addr, i_rs2_addr, i_rd_addr, i_use_pc, i_use_imm,
               i_alu_op, i_sub, i_arith_shift, i_branch_op,
               i_wb_valid, i_wb_rd, i_wb_data, i_ready,
        output o_ready, o_valid, o_a, o_b, o_rs2_val, o_op, o_branch_op,
               o_sub, o_arith_shift, o_pc, o_rd
    );

    modport master (
        output i_flush, i_valid, i_pc, i_rs1_data, i_rs2_data, i_imm,
               i_rs1_addr, i_rs2_addr, i_rd_addr, i_use_pc, i_use_imm,
               i_alu_op, i_sub, i_arith_shift, i_branch_op,
               i_wb_valid, i_wb_rd, i_wb_data, i_ready,
        input  o_ready, o_valid, o_a, o_b, o_rs2_val, o_op, o_branch_op,
               o_sub, o_arith_shift, o_pc, o_rd
    );
endinterface

// File: rtl/alu_operand_stage.sv
// Decode->execute operand stage with a 2-entry skid buffer and registered o_ready.
// Optional writeback forwarding into captured/held rs values: define OPERAND_FWD_EN.
module alu_operand_stage #(
    parameter int XLEN = 32   // the downstream ALU is 32-bit only
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    alu_operand_stage_if.slave   io_bus
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [4:0]      rd;
        logic            use_pc;
        logic            use_imm;
        logic [2:0]      op;
        logic            sub;
        logic            arith_shift;
        logic [2:0]      branch_op;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_ready;
    entry_t r_main_p1;
    entry_t r_skid_p1;
    entry_t w_in_p0;
    entry_t w_in_fwd_p0;
    entry_t w_main_fwd_p1;
    entry_t w_skid_fwd_p1;
    entry_t w_main_nxt;
    entry_t w_skid_nxt;
    logic   w_vld_p1;
    logic   w_accept;
    logic   w_xfer;

    function automatic logic [XLEN-1:0] fwd_val(
        input logic [XLEN-1:0] val,
        input logic [4:0]      addr,
        input logic            wb_v,
        input logic [4:0]      wb_rd,
        input logic [XLEN-1:0] wb_d
    );
        // x0 is hard-wired zero and must never pick up a writeback value
        return (wb_v && (wb_rd != 5'd0) && (wb_rd == addr)) ? wb_d : val;
    endfunction

    function automatic entry_t fwd_entry(
        input entry_t          e,
        input logic            wb_v,
        input logic [4:0]      wb_rd,
        input logic [XLEN-1:0] wb_d
    );
        entry_t r;
        r     = e;
        r.rs1 = fwd_val(e.rs1, e.rs1_addr, wb_v, wb_rd, wb_d);
        r.rs2 = fwd_val(e.rs2, e.rs2_addr, wb_v, wb_rd, wb_d);
        return r;
    endfunction

    // ---- stage p0: incoming instruction fields ----
    always_comb begin
        w_in_p0             = '0;
        w_in_p0.pc          = io_bus.i_pc;
        w_in_p0.rs1         = io_bus.i_rs1_data;
        w_in_p0.rs2         = io_bus.i_rs2_data;
        w_in_p0.imm         = io_bus.i_imm;
        w_in_p0.rs1_addr    = io_bus.i_rs1_addr;
        w_in_p0.rs2_addr    = io_bus.i_rs2_addr;
        w_in_p0.rd          = io_bus.i_rd_addr;
        w_in_p0.use_pc      = io_bus.i_use_pc;
        w_in_p0.use_imm     = io_bus.i_use_imm;
        w_in_p0.op          = io_bus.i_alu_op;
        w_in_p0.sub         = io_bus.i_sub;
        w_in_p0.arith_shift = io_bus.i_arith_shift;
        w_in_p0.branch_op   = io_bus.i_branch_op;
    end

`ifdef OPERAND_FWD_EN
    assign w_in_fwd_p0   = fwd_entry(w_in_p0,   io_bus.i_wb_valid, io_bus.i_wb_rd, io_bus.i_wb_data);
    assign w_main_fwd_p1 = fwd_entry(r_main_p1, io_bus.i_wb_valid, io_bus.i_wb_rd, io_bus.i_wb_data);
    assign w_skid_fwd_p1 = fwd_entry(r_skid_p1, io_bus.i_wb_valid, io_bus.i_wb_rd, io_bus.i_wb_data);
`else
    logic w_unused_fwd;
    assign w_in_fwd_p0   = w_in_p0;
    assign w_main_fwd_p1 = r_main_p1;
    assign w_skid_fwd_p1 = r_skid_p1;
    assign w_unused_fwd  = ^{io_bus.i_wb_valid, io_bus.i_wb_rd, io_bus.i_wb_data,
                             r_main_p1.rs1_addr, r_main_p1.rs2_addr};
`endif

    assign w_vld_p1 = (r_state != ST_EMPTY);
    assign w_accept = io_bus.i_valid && r_ready;
    assign w_xfer   = w_vld_p1 && io_bus.i_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = w_main_fwd_p1;
        w_skid_nxt  = w_skid_fwd_p1;
        if (io_bus.i_flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = ST_FULL;
                        w_main_nxt  = w_in_fwd_p0;
                    end
                end
                ST_FULL: begin
                    if (w_accept && !w_xfer) begin
                        w_state_nxt = ST_SKID;
                        w_skid_nxt  = w_in_fwd_p0;
                    end else if (w_xfer && !w_accept) begin
                        w_state_nxt = ST_EMPTY;
                    end else if (w_xfer && w_accept) begin
                        w_main_nxt  = w_in_fwd_p0;
                    end
                end
                ST_SKID: begin
                    if (w_xfer) begin
                        w_state_nxt = ST_FULL;
                        w_main_nxt  = w_skid_fwd_p1;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // ---- stage p1: main/skid entries ----
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_EMPTY;
            r_ready   <= 1'b1;
            r_main_p1 <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ready   <= (w_state_nxt != ST_SKID);
            r_main_p1 <= w_main_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        r_skid_p1 <= w_skid_nxt;
    end

    assign io_bus.o_ready       = r_ready;
    assign io_bus.o_valid       = w_vld_p1;
    assign io_bus.o_a           = r_main_p1.use_pc  ? r_main_p1.pc  : r_main_p1.rs1;
    assign io_bus.o_b           = r_main_p1.use_imm ? r_main_p1.imm : r_main_p1.rs2;
    assign io_bus.o_rs2_val     = r_main_p1.rs2;
    assign io_bus.o_op          = r_main_p1.op;
    assign io_bus.o_branch_op   = r_main_p1.branch_op;
    assign io_bus.o_sub         = r_main_p1.sub;
    assign io_bus.o_arith_shift = r_main_p1.arith_shift;
    assign io_bus.o_pc          = r_main_p1.pc;
    assign io_bus.o_rd          = r_main_p1.rd;

endmodule
